// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle word RAM controller with WAIT_STATES busy cycles per access.
// Define DMEM_ALIGN_CHECK_EN to add the Fault port and misaligned-access suppression.
module dmem_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0500,
  parameter int DEPTH_LOG2 = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CS,
  input  logic        RD,
  input  logic        WR,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Stall
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        Fault
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0] data;
  logic wr;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic req, fire, bad;
  assign req = CS & (RD | WR);
  assign fire = state == BUSY && cnt == 4'd0;
`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] lo;
  assign bad = lo != 2'b00;
  assign Fault = state == DONE && bad;
`else
  assign bad = 1'b0;
`endif
  always_comb begin
    state_n = state == IDLE ? (req ? BUSY : IDLE) : state == BUSY ? (fire ? DONE : BUSY) : IDLE;
    Ready = state == DONE;
    Stall = (state == IDLE && req) || state == BUSY;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= 4'd0;
      ReadData <= 32'h0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        idx <= DEPTH_LOG2'((Address - BASE_ADDR) >> 2);
        data <= WriteData;
        wr <= WR;
        cnt <= 4'(WAIT_STATES);
`ifdef DMEM_ALIGN_CHECK_EN
        lo <= Address[1:0];
`endif
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (fire && !wr && !bad) ReadData <= mem[idx];
    end
  end
  // RAM has no reset; a reset on the commit edge drops the write
  always_ff @(posedge CLK) begin
    if (!RST && fire && wr && !bad) mem[idx] <= data;
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl with default parameters.
module tb_dmem_ctrl;
  localparam int WS = 2;
  logic clk = 1'b0, rst = 1'b1, cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0, rdata;
  logic ready, stall;
  int n_chk = 0, n_fail = 0;
`ifdef DMEM_ALIGN_CHECK_EN
  logic fault;
`endif
  dmem_ctrl #(.BASE_ADDR(32'h0000_0500), .DEPTH_LOG2(8), .WAIT_STATES(WS)) dut (
    .CLK(clk),
    .RST(rst),
    .CS(cs),
    .RD(rd),
    .WR(wr),
    .Address(addr),
    .WriteData(wdata),
    .ReadData(rdata),
    .Ready(ready),
    .Stall(stall)
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    .Fault(fault)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Called #1 after a rising edge; returns #1 after the edge that leaves DONE.
  task automatic acc(input logic c, input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    cs = c; wr = w; rd = r; addr = a; wdata = d;
    for (int k = 0; k <= WS + 2; k++) begin
      @(negedge clk);
      chk("stall", 32'(stall), 32'(c && (w || r) && k <= WS + 1));
      chk("ready", 32'(ready), 32'(c && (w || r) && k == WS + 2));
`ifdef DMEM_ALIGN_CHECK_EN
      chk("fault", 32'(fault), 32'(c && (w || r) && k == WS + 2 && a[1:0] != 2'b00));
`endif
      if (k == 1) addr = 32'h0000_0000;
    end
    @(posedge clk);
    #1 cs = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    @(posedge clk);
    #1;
    acc(1, 1, 0, 32'h0500, 32'hDEAD_BEEF);
    acc(1, 0, 1, 32'h0500, 32'h0);
    chk("rd_500", rdata, 32'hDEAD_BEEF);
    acc(1, 1, 0, 32'h08FC, 32'h1234_5678);
    acc(1, 0, 1, 32'h08FC, 32'h0);
    chk("rd_8fc", rdata, 32'h1234_5678);
    acc(1, 0, 1, 32'h0500, 32'h0);
    chk("no_alias", rdata, 32'hDEAD_BEEF);
    acc(0, 0, 1, 32'h04FF, 32'h0);
    chk("cs0_lo", rdata, 32'hDEAD_BEEF);
    acc(0, 0, 1, 32'h0900, 32'h0);
    chk("cs0_hi", rdata, 32'hDEAD_BEEF);
    acc(1, 1, 1, 32'h0600, 32'hA5A5_A5A5);
    chk("rdwr_keep", rdata, 32'hDEAD_BEEF);
    acc(1, 0, 1, 32'h0600, 32'h0);
    chk("rd_600", rdata, 32'hA5A5_A5A5);
    acc(1, 1, 0, 32'h0700, 32'h0BAD_F00D);
    cs = 1'b1; wr = 1'b1; addr = 32'h0700; wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 rst = 1'b1; cs = 1'b0; wr = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < WS + 3; k++) begin
      @(negedge clk);
      chk("rst_busy_ready", 32'(ready), 32'h0);
      chk("rst_busy_stall", 32'(stall), 32'h0);
    end
    chk("rst_busy_rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    acc(1, 0, 1, 32'h0700, 32'h0);
    chk("rd_700_old", rdata, 32'h0BAD_F00D);
`ifdef DMEM_ALIGN_CHECK_EN
    acc(1, 1, 0, 32'h0502, 32'h0000_0000);
    acc(1, 0, 1, 32'h0503, 32'h0);
    chk("mis_rd_keep", rdata, 32'h0BAD_F00D);
    acc(1, 0, 1, 32'h0500, 32'h0);
    chk("mis_wr_drop", rdata, 32'hDEAD_BEEF);
`else
    acc(1, 0, 1, 32'h0503, 32'h0);
    chk("rd_503_word", rdata, 32'hDEAD_BEEF);
    acc(1, 1, 0, 32'h08FE, 32'hCAFE_0001);
    acc(1, 0, 1, 32'h08FC, 32'h0);
    chk("wr_8fe_word", rdata, 32'hCAFE_0001);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
